// File: rtl/bg_tile_pkg.sv
// -----------------------------------------------------------------------------
// bg_tile_pkg
// Shared constants and types for the background tile engine.
//   - Screen and tile geometry (64x48-pixel tiles on a 640x480 screen).
//   - Tile-map depth (128 entries; only 0..99 are displayed).
//   - tile_id_t / rgb12_t and the tile-id enumeration.
// -----------------------------------------------------------------------------
package bg_tile_pkg;

    localparam int TILE_W    = 64;
    localparam int TILE_H    = 48;
    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int MAP_DEPTH = 128;

    typedef logic [3:0]  tile_id_t;
    typedef logic [11:0] rgb12_t;

    typedef enum logic [3:0] {
        TILE_NONE  = 4'd0,
        TILE_DIRT  = 4'd1,
        TILE_BRICK = 4'd2
    } tile_kind_e;

endpackage

// File: rtl/bg_tile_rom.sv
// -----------------------------------------------------------------------------
// bg_tile_rom
// Combinational procedural tile lookup: colour of one pixel inside a tile.
// Ports:
//   tile_id_i   in  4   tile id (0 none, 1 dirt, 2 brick, 3..15 reserved/black)
//   pix_addr_i  in  12  {row[5:0], col[5:0]} inside the tile
//   pixel_o     out 12  RGB colour {R,G,B}
// -----------------------------------------------------------------------------
module bg_tile_rom
    import bg_tile_pkg::*;
#(
    parameter logic [11:0] DIRT_COLOR   = 12'h841,
    parameter logic [11:0] SPECK_COLOR  = 12'hA62,
    parameter logic [11:0] BRICK_COLOR  = 12'hC42,
    parameter logic [11:0] MORTAR_COLOR = 12'h888
) (
    input  logic [3:0]  tile_id_i,
    input  logic [11:0] pix_addr_i,
    output logic [11:0] pixel_o
);

    logic [5:0] r_s;
    logic [5:0] c_s;

    assign r_s = pix_addr_i[11:6];
    assign c_s = pix_addr_i[5:0];

    // Procedural tile pattern: diagonal speckles for dirt, mortar lines for brick.
    always_comb begin
        pixel_o = 12'h000;
        case (tile_id_i)
            TILE_NONE: begin
                pixel_o = 12'h000;
            end
            TILE_DIRT: begin
                if (((r_s ^ c_s) & 6'd7) == 6'd0) begin
                    pixel_o = SPECK_COLOR;
                end else begin
                    pixel_o = DIRT_COLOR;
                end
            end
            TILE_BRICK: begin
                // Bottom row, right column and the mid row form the mortar joints.
                if ((r_s == 6'd47) || (c_s == 6'd63) || (r_s == 6'd23)) begin
                    pixel_o = MORTAR_COLOR;
                end else begin
                    pixel_o = BRICK_COLOR;
                end
            end
            default: begin
                pixel_o = 12'h000;
            end
        endcase
    end

endmodule

// File: rtl/bg_tile_renderer.sv
// -----------------------------------------------------------------------------
// bg_tile_renderer
// Background tile engine: maps the scan position (hpos/vpos) through a
// writable 128x4 tile map and procedural tile ROMs to a 12-bit background
// colour with a fixed 3-cycle latency, one pixel per clock.
// Ports:
//   clk25m    in  1   pixel clock
//   rst_n     in  1   asynchronous active-low reset (pipeline only, not the map)
//   wr_en     in  1   tile-map write strobe
//   wr_addr   in  7   tile-map write index
//   wr_data   in  4   tile id to store
//   hpos      in  10  current pixel column
//   vpos      in  10  current pixel row
//   bg_color  out 12  registered background colour {R,G,B}
// Build option:
//   BG_GRID_OVERLAY_EN  when defined, visible pixels on tile row 0 or
//                       column 0 are forced to white (debug grid).
// -----------------------------------------------------------------------------
module bg_tile_renderer
    import bg_tile_pkg::*;
#(
    parameter int          MAP_COLS     = 10,
    parameter int          MAP_ROWS     = 10,
    parameter logic [11:0] DIRT_COLOR   = 12'h841,
    parameter logic [11:0] SPECK_COLOR  = 12'hA62,
    parameter logic [11:0] BRICK_COLOR  = 12'hC42,
    parameter logic [11:0] MORTAR_COLOR = 12'h888
) (
    input  logic        clk25m,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [6:0]  wr_addr,
    input  logic [3:0]  wr_data,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    output logic [11:0] bg_color
);

    localparam logic [9:0] TILE_W_C   = 10'(TILE_W);
    localparam logic [9:0] TILE_H_C   = 10'(TILE_H);
    localparam logic [9:0] SCREEN_W_C = 10'(SCREEN_W);
    localparam logic [9:0] SCREEN_H_C = 10'(SCREEN_H);
    localparam logic [9:0] MAP_COLS_C = 10'(MAP_COLS);
    localparam logic [9:0] MAP_ROWS_C = 10'(MAP_ROWS);

    // Tile map; deliberately not reset so contents survive a pipeline reset.
    logic [3:0]  map_q [0:MAP_DEPTH-1];

    logic [9:0]  row_s;
    logic [9:0]  col_s;
    logic [6:0]  map_idx_d;
    logic [11:0] pix_addr_d;
    logic        vis_d;

    logic [6:0]  map_idx_q;
    logic [11:0] pix_addr_q;
    logic        vis_q;
    logic [3:0]  tile_id_q;
    logic [11:0] s2_pix_addr_q;
    logic        s2_vis_q;
    logic [11:0] tile_pixel_s;
    logic [11:0] bg_color_d;
    logic [11:0] bg_color_q;

    // Stage-1 address decode: constant divide/modulo by tile size.
    always_comb begin
        row_s      = vpos / TILE_H_C;
        col_s      = hpos / TILE_W_C;
        // Out-of-range positions may alias here; vis_d masks them later.
        map_idx_d  = 7'((row_s * MAP_COLS_C) + col_s);
        pix_addr_d = {6'(vpos % TILE_H_C), 6'(hpos % TILE_W_C)};
        vis_d      = (hpos < SCREEN_W_C) && (vpos < SCREEN_H_C) &&
                     (row_s < MAP_ROWS_C) && (col_s < MAP_COLS_C);
    end

    // Tile-map write port.
    always_ff @(posedge clk25m) begin
        if (wr_en) begin
            map_q[wr_addr] <= wr_data;
        end
    end

    bg_tile_rom #(
        .DIRT_COLOR   (DIRT_COLOR),
        .SPECK_COLOR  (SPECK_COLOR),
        .BRICK_COLOR  (BRICK_COLOR),
        .MORTAR_COLOR (MORTAR_COLOR)
    ) u_rom (
        .tile_id_i  (tile_id_q),
        .pix_addr_i (s2_pix_addr_q),
        .pixel_o    (tile_pixel_s)
    );

    // Stage-3 colour select, blanking off-screen pixels.
    always_comb begin
        bg_color_d = 12'h000;
`ifdef BG_GRID_OVERLAY_EN
        if (s2_vis_q && ((s2_pix_addr_q[11:6] == 6'd0) || (s2_pix_addr_q[5:0] == 6'd0))) begin
            bg_color_d = 12'hFFF;
        end else if (s2_vis_q) begin
            bg_color_d = tile_pixel_s;
        end else begin
            bg_color_d = 12'h000;
        end
`else
        if (s2_vis_q) begin
            bg_color_d = tile_pixel_s;
        end else begin
            bg_color_d = 12'h000;
        end
`endif
    end

    // Three-stage pixel pipeline; the map read sits in stage 2 and is
    // read-first against a same-cycle write because both use NBAs.
    always_ff @(posedge clk25m or negedge rst_n) begin
        if (!rst_n) begin
            map_idx_q     <= 7'd0;
            pix_addr_q    <= 12'd0;
            vis_q         <= 1'b0;
            tile_id_q     <= 4'd0;
            s2_pix_addr_q <= 12'd0;
            s2_vis_q      <= 1'b0;
            bg_color_q    <= 12'h000;
        end else begin
            map_idx_q     <= map_idx_d;
            pix_addr_q    <= pix_addr_d;
            vis_q         <= vis_d;
            tile_id_q     <= map_q[map_idx_q];
            s2_pix_addr_q <= pix_addr_q;
            s2_vis_q      <= vis_q;
            bg_color_q    <= bg_color_d;
        end
    end

    assign bg_color = bg_color_q;

endmodule

// File: tb/tb_bg_tile_renderer.sv
// -----------------------------------------------------------------------------
// tb_bg_tile_renderer
// Scoreboard bench: each driven pixel gets an expected colour from a
// geometric reference model (screen -> tile -> pattern arithmetic), queued
// with the cycle at which it must appear; a monitor pops and compares.
// Honours BG_GRID_OVERLAY_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_bg_tile_renderer;

    logic        clk25m;
    logic        rst_n;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [3:0]  wr_data;
    logic [9:0]  hpos;
    logic [9:0]  vpos;
    logic [11:0] bg_color;

    bg_tile_renderer dut (
        .clk25m   (clk25m),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .hpos     (hpos),
        .vpos     (vpos),
        .bg_color (bg_color)
    );

    initial clk25m = 1'b0;
    always #20 clk25m = ~clk25m;

    typedef struct {
        int          due;
        int          x;
        int          y;
        logic [11:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   model_map[128];
    int   edge_cnt;
    int   n_cmp;
    int   n_err;
    int   prev_x;
    int   prev_y;
    bit   prev_valid;

    // Reference: what a 640x480 screen of 64x48 tiles should show at (x,y).
    function automatic logic [11:0] ref_pixel(input int x, input int y);
        int id;
        int r;
        int c;
        if (x >= 640 || y >= 480) return 12'h000;
        id = model_map[(y / 48) * 10 + (x / 64)];
        r  = y % 48;
        c  = x % 64;
`ifdef BG_GRID_OVERLAY_EN
        if (r == 0 || c == 0) return 12'hFFF;
`endif
        if (id == 1) return (((r ^ c) % 8) == 0) ? 12'hA62 : 12'h841;
        if (id == 2) return (r == 47 || c == 63 || r == 23) ? 12'h888 : 12'hC42;
        return 12'h000;
    endfunction

    // Drive one pixel (and optional map write) across one clock edge.
    // The pixel sampled on the previous edge reads the map on this edge,
    // before this edge's write, and appears after the next edge.
    task automatic step(input int x, input int y, input bit we, input int wa, input int wd);
        exp_t e;
        hpos    = 10'(x);
        vpos    = 10'(y);
        wr_en   = we;
        wr_addr = 7'(wa);
        wr_data = 4'(wd);
        @(posedge clk25m);
        edge_cnt = edge_cnt + 1;
        if (prev_valid && rst_n) begin
            e.due = edge_cnt + 1;
            e.x   = prev_x;
            e.y   = prev_y;
            e.exp = ref_pixel(prev_x, prev_y);
            sb_q.push_back(e);
        end
        if (we) model_map[wa] = wd;
        prev_x     = x;
        prev_y     = y;
        prev_valid = rst_n;
        #2;
        wr_en = 1'b0;
    endtask

    initial begin
        edge_cnt   = 0;
        n_cmp      = 0;
        n_err      = 0;
        prev_valid = 1'b0;
        prev_x     = 0;
        prev_y     = 0;
        for (int i = 0; i < 128; i++) model_map[i] = 0;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 7'd0;
        wr_data = 4'd0;
        hpos    = 10'd0;
        vpos    = 10'd0;

        // Monitor: compare the DUT against the head of the queue when it falls due.
        fork
            forever begin
                exp_t m;
                @(negedge clk25m);
                while (sb_q.size() > 0 && sb_q[0].due < edge_cnt) begin
                    m = sb_q.pop_front();
                    n_cmp = n_cmp + 1;
                    n_err = n_err + 1;
                    $display("FAIL stale (%0d,%0d): no compare at edge %0d, expected %h", m.x, m.y, m.due, m.exp);
                end
                if (sb_q.size() > 0 && sb_q[0].due == edge_cnt) begin
                    m = sb_q.pop_front();
                    n_cmp = n_cmp + 1;
                    if (bg_color !== m.exp) begin
                        n_err = n_err + 1;
                        $display("FAIL pixel (%0d,%0d): got %h expected %h", m.x, m.y, bg_color, m.exp);
                    end
                end
            end
        join_none

        // Reset held: output must stay black even with on-screen positions.
        for (int i = 0; i < 4; i++) begin
            step(i * 70, i * 50, 1'b0, 0, 0);
            @(negedge clk25m);
            n_cmp = n_cmp + 1;
            if (bg_color !== 12'h000) begin
                n_err = n_err + 1;
                $display("FAIL reset_hold: got %h expected 000", bg_color);
            end
        end
        rst_n = 1'b1;

        // Untouched map: a coarse frame sweep including blanking area.
        for (int y = 0; y < 525; y += 11)
            for (int x = 0; x < 800; x += 17)
                step(x, y, 1'b0, 0, 0);

        // Dirt at index 0: speckle at (0,0), body at (1,0).
        step(700, 500, 1'b1, 0, 1);
        step(0, 0, 1'b0, 0, 0);
        step(1, 0, 1'b0, 0, 0);
        step(9, 1, 1'b0, 0, 0);

        // Brick at index 11: body, right mortar column, mid mortar row.
        step(700, 500, 1'b1, 11, 2);
        step(69, 53, 1'b0, 0, 0);
        step(127, 60, 1'b0, 0, 0);
        step(69, 71, 1'b0, 0, 0);
        step(64, 95, 1'b0, 0, 0);

        // Screen corner and first off-screen column.
        step(700, 500, 1'b1, 99, 1);
        step(639, 479, 1'b0, 0, 0);
        step(640, 0, 1'b0, 0, 0);
        step(1023, 1023, 1'b0, 0, 0);

        // Hidden entry 100 must not show anywhere.
        step(700, 500, 1'b1, 100, 2);
        for (int y = 0; y < 480; y += 23)
            for (int x = 0; x < 640; x += 29)
                step(x, y, 1'b0, 0, 0);
        step(639, 479, 1'b0, 0, 0);

        // Collision: (0,0) reads map[0] on the same edge map[0] becomes brick.
        step(0, 0, 1'b0, 0, 0);
        step(63, 0, 1'b1, 0, 2);
        step(63, 0, 1'b0, 0, 0);
        step(0, 0, 1'b0, 0, 0);

        // Async reset mid-stream while the output is brick-coloured.
        step(5, 5, 1'b0, 0, 0);
        step(5, 5, 1'b0, 0, 0);
        step(5, 5, 1'b0, 0, 0);
        #3;
        rst_n = 1'b0;
        sb_q.delete();
        prev_valid = 1'b0;
        #1;
        n_cmp = n_cmp + 1;
        if (bg_color !== 12'h000) begin
            n_err = n_err + 1;
            $display("FAIL async_reset: got %h expected 000", bg_color);
        end
        step(5, 5, 1'b0, 0, 0);
        step(5, 5, 1'b0, 0, 0);
        @(negedge clk25m);
        rst_n = 1'b1;
        // Map contents survive the reset.
        step(5, 5, 1'b0, 0, 0);
        step(63, 0, 1'b0, 0, 0);
        step(10, 30, 1'b0, 0, 0);

        // Random traffic: mostly visible positions, occasional map writes.
        for (int i = 0; i < 3000; i++) begin
            int x;
            int y;
            bit we;
            int wd;
            x  = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 639)) : int'($urandom_range(0, 1023));
            y  = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 479)) : int'($urandom_range(0, 1023));
            we = ($urandom_range(0, 3) == 0);
            wd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
            step(x, y, we, int'($urandom_range(0, 127)), wd);
        end

        // Drain: flush the pipeline, then wait a bounded number of edges.
        step(900, 600, 1'b0, 0, 0);
        step(900, 600, 1'b0, 0, 0);
        prev_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk25m);
            edge_cnt = edge_cnt + 1;
            @(negedge clk25m);
            #1;
        end
        if (sb_q.size() != 0) begin
            n_cmp = n_cmp + 1;
            n_err = n_err + 1;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
